// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with a hold-limited grant.
// The registered owner index steers the shared datapath mux and is decoded to a one-hot grant.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [2:0]       r_ptr;
  logic             r_busy;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [2:0]       w_winner;

  // Scans from ptr+7 down to ptr so the last hit is the first set bit in search order.
  function automatic logic [2:0] f_pick(input logic [7:0] req_v, input logic [2:0] ptr_v);
    logic [2:0] pick;
    logic [2:0] k;
    pick = ptr_v;
    for (int i = 7; i >= 0; i--) begin
      k = ptr_v + i[2:0];
      if (req_v[k]) pick = k;
    end
    return pick;
  endfunction

  assign w_winner = f_pick(req, r_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_ptr      <= 3'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req != 8'h00) begin
            r_state    <= S_BUSY;
            r_idx      <= w_winner;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          // done outranks the hold limit, so a done on the last hold cycle is a clean release.
          if (done || !req[r_idx]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= r_idx + 3'd1;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_ptr     <= r_idx + 3'd1;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant     = r_busy ? (8'b0000_0001 << r_idx) : 8'h00;
  assign grant_idx = r_idx;
  assign busy      = r_busy;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: reset, rotation, hold timeout, request drop, mid-grant reset.
module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_err;

  rr_decode_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, ".grant"},   32'(grant),   32'h00);
    chk({tag, ".busy"},    32'(busy),    32'h0);
    chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  task automatic chk_owner(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    chk({tag, ".grant"},   32'(grant),     32'(oh));
    chk({tag, ".idx"},     32'(grant_idx), 32'(idx));
    chk({tag, ".busy"},    32'(busy),      32'h1);
    chk({tag, ".timeout"}, 32'(timeout),   32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 8'hFF;
    done  = 1'b0;

    // T1: reset held with all requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("t1_rst", 1'b0);
      chk("t1_rst.idx", 32'(grant_idx), 32'h0);
    end

    // T2: two requesters, done hands over to the next in order
    rst = 1'b0;
    req = 8'b0000_0101;
    tick();
    chk_owner("t2_first", 3'd0);
    done = 1'b1;
    tick();
    chk_idle("t2_gap", 1'b0);
    done = 1'b0;
    tick();
    chk_owner("t2_second", 3'd2);
    req = 8'h00;
    tick();
    chk_idle("t2_drop", 1'b0);

    // T3: full rotation with done two cycles into each grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk_owner("t3_grant", 3'(g % 8));
      tick();
      chk("t3_hold.busy", 32'(busy), 32'h1);
      done = 1'b1;
      tick();
      chk_idle("t3_gap", 1'b0);
      done = 1'b0;
    end

    // T4: single requester runs into the hold limit
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'h08;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk_owner("t4_hold", 3'd3);
    end
    tick();
    chk_idle("t4_timeout", 1'b1);
    tick();
    chk_owner("t4_regrant", 3'd3);
    for (int c = 0; c < 15; c++) tick();
    chk_owner("t4_last_cycle", 3'd3);
    done = 1'b1;
    tick();
    chk_idle("t4_done_on_limit", 1'b0);
    done = 1'b0;
    req  = 8'h00;
    tick();
    chk_idle("t4_quiet", 1'b0);

    // T5: owner drops its request; pointer must move past it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'h30;
    tick();
    chk_owner("t5_grant", 3'd4);
    tick();
    req = 8'h28;
    tick();
    chk_idle("t5_drop", 1'b0);
    tick();
    chk_owner("t5_next", 3'd5);

    // T6: reset while idx 5 owns the grant
    rst = 1'b1;
    req = 8'hFF;
    tick();
    chk_idle("t6_rst", 1'b0);
    chk("t6_rst.idx", 32'(grant_idx), 32'h0);
    rst = 1'b0;
    tick();
    chk_owner("t6_after", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
